// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register: control-bit positions,
// the reference payload layout at default widths, and a control gating helper.
package ex_mem_stage_reg_pkg;

    localparam int CTRL_W        = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMTOREG = 0;

    // Reference layout for the default 32-bit datapath / 5-bit register address.
    typedef struct packed {
        logic [31:0]       branch_target;
        logic              zero_flag;
        logic [31:0]       alu_result;
        logic [31:0]       read_data2;
        logic [4:0]        write_reg;
        logic [CTRL_W-1:0] ctrl;
    } ex_mem_payload_t;

    // An invalid slot must never present MemWrite/RegWrite downstream.
    function automatic logic [CTRL_W-1:0] ctrl_gate(input logic valid,
                                                    input logic [CTRL_W-1:0] ctrl);
        return valid ? ctrl : '0;
    endfunction

endpackage

// File: rtl/ex_mem_stage_reg_entry.sv
// One pipeline slot: a valid flag plus payload register with load, unload and clear.
// Priority is reset, then clear, then load, then unload; payload is held unless loaded.
module pipe_skid_entry
    import ex_mem_stage_reg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= d;
        end else if (unload) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign q     = data_reg;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with valid/ready flow control, optional skid slot,
// branch flush, forwarding info and a saturating MEM-stall counter.
module ex_mem_stage_reg
    import ex_mem_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SKID       = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     branchTarget,
    input  logic                  zeroFlag,
    input  logic [DATA_W-1:0]     ALUResult,
    input  logic [DATA_W-1:0]     readData2,
    input  logic [REG_ADDR_W-1:0] writeReg,
    input  logic [4:0]            ctrl,
    input  logic                  hit,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     branchTargetOut,
    output logic                  zeroFlagOut,
    output logic [DATA_W-1:0]     ALUResultOut,
    output logic [DATA_W-1:0]     readData2Out,
    output logic [REG_ADDR_W-1:0] writeRegOut,
    output logic [4:0]            ctrlOut,
    output logic                  fwd_valid,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0]     branch_target;
        logic                  zero_flag;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     read_data2;
        logic [REG_ADDR_W-1:0] write_reg;
        logic [CTRL_W-1:0]     ctrl;
    } payload_t;

    localparam int PW          = $bits(payload_t);
    localparam int NUM_ENTRIES = (SKID != 0) ? 2 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Slot 0 is the main entry M driving the outputs; slot 1 is the skid entry S.
    logic [1:0] entry_clear;
    logic [1:0] entry_load;
    logic [1:0] entry_unload;
    logic [1:0] entry_valid;
    payload_t   entry_d [2];
    payload_t   entry_q [2];

    payload_t   in_payload;
    logic       in_fire;
    logic       out_fire;
    logic       m_free;

    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    assign in_payload = {branchTarget, zeroFlag, ALUResult, readData2, writeReg, ctrl};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            if (gi < NUM_ENTRIES) begin : g_on
                pipe_skid_entry #(.W(PW)) u_entry (
                    .clk    (clk),
                    .reset  (reset),
                    .clear  (entry_clear[gi]),
                    .load   (entry_load[gi]),
                    .unload (entry_unload[gi]),
                    .d      (entry_d[gi]),
                    .valid  (entry_valid[gi]),
                    .q      (entry_q[gi])
                );
            end else begin : g_off
                assign entry_valid[gi] = 1'b0;
                assign entry_q[gi]     = '0;
            end
        end
    endgenerate

    // With a skid slot, in_ready depends only on the S flop, never on hit.
    assign in_ready = (SKID != 0) ? ~entry_valid[1] : (~entry_valid[0] | hit);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = entry_valid[0] & hit;
    assign m_free   = ~entry_valid[0] | out_fire;

    always_comb begin
        entry_clear  = {2{flush}};
        entry_load   = 2'b00;
        entry_unload = 2'b00;
        entry_d[0]   = in_payload;
        entry_d[1]   = in_payload;
        if (!flush) begin
            if (m_free) begin
                if (entry_valid[1]) begin
                    // Oldest beat lives in S, so it advances before any new input.
                    entry_load[0] = 1'b1;
                    entry_d[0]    = entry_q[1];
                    if (in_fire) begin
                        entry_load[1] = 1'b1;
                    end else begin
                        entry_unload[1] = 1'b1;
                    end
                end else if (in_fire) begin
                    entry_load[0] = 1'b1;
                end else begin
                    entry_unload[0] = 1'b1;
                end
            end else if (in_fire) begin
                entry_load[1] = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (entry_valid[0] && !hit && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    // Flush leaves the counter alone: it measures MEM stall time across flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign out_valid       = entry_valid[0];
    assign branchTargetOut = entry_q[0].branch_target;
    assign zeroFlagOut     = entry_q[0].zero_flag;
    assign ALUResultOut    = entry_q[0].alu_result;
    assign readData2Out    = entry_q[0].read_data2;
    assign writeRegOut     = entry_q[0].write_reg;
    assign ctrlOut         = ctrl_gate(entry_valid[0], entry_q[0].ctrl);
    assign fwd_valid       = entry_valid[0] & entry_q[0].ctrl[CTRL_REGWRITE]
                           & (entry_q[0].write_reg != '0);
    assign stall_cnt       = stall_cnt_reg;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench: a skid-buffered instance (CNT_W=16) and a single-entry
// instance (CNT_W=2) share stimulus; each task checks its own scenario.
module tb_ex_mem_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] branchTarget;
    logic        zeroFlag;
    logic [31:0] ALUResult;
    logic [31:0] readData2;
    logic [4:0]  writeReg;
    logic [4:0]  ctrl;
    logic        hit;

    logic        in_ready, out_valid, zeroFlagOut, fwd_valid;
    logic [31:0] branchTargetOut, ALUResultOut, readData2Out;
    logic [4:0]  writeRegOut, ctrlOut;
    logic [15:0] stall_cnt;

    logic        s0_in_ready, s0_out_valid, s0_zeroFlagOut, s0_fwd_valid;
    logic [31:0] s0_branchTargetOut, s0_ALUResultOut, s0_readData2Out;
    logic [4:0]  s0_writeRegOut, s0_ctrlOut;
    logic [1:0]  s0_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .branchTarget(branchTarget), .zeroFlag(zeroFlag), .ALUResult(ALUResult),
        .readData2(readData2), .writeReg(writeReg), .ctrl(ctrl), .hit(hit),
        .out_valid(out_valid), .branchTargetOut(branchTargetOut), .zeroFlagOut(zeroFlagOut),
        .ALUResultOut(ALUResultOut), .readData2Out(readData2Out), .writeRegOut(writeRegOut),
        .ctrlOut(ctrlOut), .fwd_valid(fwd_valid), .stall_cnt(stall_cnt)
    );

    ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(0), .CNT_W(2)) dut_s0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s0_in_ready),
        .branchTarget(branchTarget), .zeroFlag(zeroFlag), .ALUResult(ALUResult),
        .readData2(readData2), .writeReg(writeReg), .ctrl(ctrl), .hit(hit),
        .out_valid(s0_out_valid), .branchTargetOut(s0_branchTargetOut),
        .zeroFlagOut(s0_zeroFlagOut), .ALUResultOut(s0_ALUResultOut),
        .readData2Out(s0_readData2Out), .writeRegOut(s0_writeRegOut),
        .ctrlOut(s0_ctrlOut), .fwd_valid(s0_fwd_valid), .stall_cnt(s0_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b fl=%0b in_v=%0b hit=%0b | out_v=%0b alu_out=%0d ctrl_out=%05b in_rdy=%0b fwd=%0b cnt=%0d | s0 out_v=%0b cnt=%0d",
                 $time, reset, flush, in_valid, hit, out_valid, ALUResultOut, ctrlOut,
                 in_ready, fwd_valid, stall_cnt, s0_out_valid, s0_stall_cnt);
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [31:0] bt, input logic [4:0] wr, input logic [4:0] c,
                         input logic h);
        in_valid     = v;
        ALUResult    = alu;
        readData2    = rd2;
        branchTarget = bt;
        writeReg     = wr;
        ctrl         = c;
        hit          = h;
        zeroFlag     = alu[0];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'd99, 32'd98, 32'd97, 5'd7, 5'b11111, 1'b0);
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
        n_cmp++; if (ALUResultOut !== 32'd0) begin n_bad++; $display("FAIL reset_alu_out got %0h want 0", ALUResultOut); end
        n_cmp++; if (ctrlOut !== 5'd0) begin n_bad++; $display("FAIL reset_ctrl_out got %0h want 0", ctrlOut); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall_cnt got %0h want 0", stall_cnt); end
        n_cmp++; if (s0_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_s0_out_valid got %0h want 0", s0_out_valid); end
        reset = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    endtask

    task automatic test_single();
        drive(1'b1, 32'd12, 32'd23, 32'd2, 5'd0, 5'b00100, 1'b1);
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_out_valid got %0h want 1", out_valid); end
        n_cmp++; if (ALUResultOut !== 32'd12) begin n_bad++; $display("FAIL single_alu_out got %0h want c", ALUResultOut); end
        n_cmp++; if (readData2Out !== 32'd23) begin n_bad++; $display("FAIL single_rd2_out got %0h want 17", readData2Out); end
        n_cmp++; if (branchTargetOut !== 32'd2) begin n_bad++; $display("FAIL single_bt_out got %0h want 2", branchTargetOut); end
        n_cmp++; if (ctrlOut[2] !== 1'b1) begin n_bad++; $display("FAIL single_branch_out got %0h want 1", ctrlOut[2]); end
        n_cmp++; if (zeroFlagOut !== 1'b0) begin n_bad++; $display("FAIL single_zero_out got %0h want 0", zeroFlagOut); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain_valid got %0h want 0", out_valid); end
        n_cmp++; if (ctrlOut !== 5'd0) begin n_bad++; $display("FAIL single_drain_ctrl got %0h want 0", ctrlOut); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 32'(i + 100), 32'(i + 200), 5'(i), 5'b00010, 1'b1);
            tick();
            n_cmp++; if (ALUResultOut !== 32'(i)) begin n_bad++; $display("FAIL stream_alu_out beat %0d got %0h want %0h", i, ALUResultOut, i); end
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_out_valid beat %0d got %0h want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready beat %0d got %0h want 1", i, in_ready); end
            n_cmp++; if (s0_ALUResultOut !== 32'(i)) begin n_bad++; $display("FAIL stream_s0_alu_out beat %0d got %0h want %0h", i, s0_ALUResultOut, i); end
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain_valid got %0h want 0", out_valid); end
    endtask

    task automatic test_skid();
        drive(1'b1, 32'd6, 32'd0, 32'd0, 5'd1, 5'b00010, 1'b1);
        tick();
        drive(1'b1, 32'd7, 32'd0, 32'd0, 5'd1, 5'b00010, 1'b0);
        #1;
        n_cmp++; if (s0_in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_s0_in_ready_stall got %0h want 0", s0_in_ready); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL skid_in_ready_before got %0h want 1", in_ready); end
        tick();
        n_cmp++; if (ALUResultOut !== 32'd6) begin n_bad++; $display("FAIL skid_hold1_alu got %0h want 6", ALUResultOut); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_in_ready_full got %0h want 0", in_ready); end
        drive(1'b1, 32'd8, 32'd0, 32'd0, 5'd1, 5'b00010, 1'b0);
        tick();
        n_cmp++; if (ALUResultOut !== 32'd6) begin n_bad++; $display("FAIL skid_hold2_alu got %0h want 6", ALUResultOut); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_in_ready_wait got %0h want 0", in_ready); end
        n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL skid_stall_cnt got %0h want 2", stall_cnt); end
        drive(1'b1, 32'd8, 32'd0, 32'd0, 5'd1, 5'b00010, 1'b1);
        tick();
        n_cmp++; if (ALUResultOut !== 32'd7) begin n_bad++; $display("FAIL skid_order7_alu got %0h want 7", ALUResultOut); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL skid_in_ready_drained got %0h want 1", in_ready); end
        tick();
        n_cmp++; if (ALUResultOut !== 32'd8) begin n_bad++; $display("FAIL skid_order8_alu got %0h want 8", ALUResultOut); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL skid_order8_valid got %0h want 1", out_valid); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL skid_no_dup_valid got %0h want 0", out_valid); end
        n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL skid_stall_cnt_end got %0h want 2", stall_cnt); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'd20, 32'd0, 32'd0, 5'd3, 5'b01010, 1'b1);
        tick();
        n_cmp++; if (ctrlOut !== 5'b01010) begin n_bad++; $display("FAIL flush_pre_ctrl got %0h want a", ctrlOut); end
        drive(1'b1, 32'd21, 32'd0, 32'd0, 5'd3, 5'b01010, 1'b0);
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_pre_in_ready got %0h want 0", in_ready); end
        flush = 1'b1;
        drive(1'b1, 32'd22, 32'd0, 32'd0, 5'd3, 5'b01010, 1'b0);
        tick();
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %0h want 0", out_valid); end
        n_cmp++; if (ctrlOut !== 5'd0) begin n_bad++; $display("FAIL flush_ctrl_out got %0h want 0", ctrlOut); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got %0h want 1", in_ready); end
        n_cmp++; if (fwd_valid !== 1'b0) begin n_bad++; $display("FAIL flush_fwd got %0h want 0", fwd_valid); end
        n_cmp++; if (s0_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_s0_out_valid got %0h want 0", s0_out_valid); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_skid_killed got %0h want 0", out_valid); end
        n_cmp++; if (stall_cnt !== 16'd4) begin n_bad++; $display("FAIL flush_stall_cnt got %0h want 4", stall_cnt); end
        n_cmp++; if (s0_stall_cnt !== 2'd3) begin n_bad++; $display("FAIL flush_s0_stall_cnt got %0h want 3", s0_stall_cnt); end
        flush = 1'b1;
        drive(1'b1, 32'd23, 32'd0, 32'd0, 5'd4, 5'b00010, 1'b1);
        tick();
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_accept_drop got %0h want 0", out_valid); end
        n_cmp++; if (s0_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_accept_drop_s0 got %0h want 0", s0_out_valid); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_accept_late got %0h want 0", out_valid); end
    endtask

    task automatic test_fwd();
        drive(1'b1, 32'd40, 32'd0, 32'd0, 5'd0, 5'b00010, 1'b1);
        tick();
        n_cmp++; if (fwd_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_r0 got %0h want 0", fwd_valid); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fwd_r0_valid got %0h want 1", out_valid); end
        drive(1'b1, 32'd41, 32'd0, 32'd0, 5'd9, 5'b00010, 1'b1);
        tick();
        n_cmp++; if (fwd_valid !== 1'b1) begin n_bad++; $display("FAIL fwd_r9 got %0h want 1", fwd_valid); end
        n_cmp++; if (writeRegOut !== 5'd9) begin n_bad++; $display("FAIL fwd_r9_wreg got %0h want 9", writeRegOut); end
        drive(1'b1, 32'd42, 32'd0, 32'd0, 5'd9, 5'b01000, 1'b1);
        tick();
        n_cmp++; if (fwd_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_no_regwrite got %0h want 0", fwd_valid); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd9, 5'b00010, 1'b1);
        tick();
        n_cmp++; if (fwd_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_invalid got %0h want 0", fwd_valid); end
    endtask

    task automatic test_saturate();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 32'd30, 32'd31, 32'd32, 5'd5, 5'b10001, 1'b1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++; if (stall_cnt !== 16'(k)) begin n_bad++; $display("FAIL sat_cnt16 cycle %0d got %0h want %0h", k, stall_cnt, k); end
            n_cmp++; if (s0_stall_cnt !== ((k > 3) ? 2'd3 : 2'(k))) begin n_bad++; $display("FAIL sat_cnt2 cycle %0d got %0h want %0h", k, s0_stall_cnt, (k > 3) ? 3 : k); end
            n_cmp++; if (ALUResultOut !== 32'd30) begin n_bad++; $display("FAIL sat_hold_alu cycle %0d got %0h want 1e", k, ALUResultOut); end
        end
        reset = 1'b1;
        drive(1'b1, 32'd55, 32'd55, 32'd55, 5'd5, 5'b11111, 1'b0);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got %0h want 0", out_valid); end
        n_cmp++; if (ALUResultOut !== 32'd0) begin n_bad++; $display("FAIL midrst_alu got %0h want 0", ALUResultOut); end
        n_cmp++; if (readData2Out !== 32'd0) begin n_bad++; $display("FAIL midrst_rd2 got %0h want 0", readData2Out); end
        n_cmp++; if (branchTargetOut !== 32'd0) begin n_bad++; $display("FAIL midrst_bt got %0h want 0", branchTargetOut); end
        n_cmp++; if (writeRegOut !== 5'd0) begin n_bad++; $display("FAIL midrst_wreg got %0h want 0", writeRegOut); end
        n_cmp++; if (ctrlOut !== 5'd0) begin n_bad++; $display("FAIL midrst_ctrl got %0h want 0", ctrlOut); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_cnt got %0h want 0", stall_cnt); end
        n_cmp++; if (s0_stall_cnt !== 2'd0) begin n_bad++; $display("FAIL midrst_s0_cnt got %0h want 0", s0_stall_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got %0h want 1", in_ready); end
        reset = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        test_reset();
        test_single();
        test_stream();
        test_skid();
        test_flush();
        test_fwd();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
